// File: rtl/reloj_soc_time_logger.sv
// BCD hh:mm:ss clock with a once-per-second timestamp logger.
// Each tick writes {seq, time} into a circular RAM buffer through an
// Avalon-MM write master. The block only ever writes to the RAM.
module reloj_soc_time_logger #(
    parameter int TICK_DIV    = 50000000,
    parameter int ADDR_W      = 11,
    parameter int BASE_WORD   = 0,
    parameter int DEPTH_WORDS = 2048
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              set_valid,
    input  logic [23:0]       set_time,
    output logic [23:0]       time_bcd,
    output logic              set_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic              overrun
);
    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_WORD);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(BASE_WORD + DEPTH_WORDS - 1);

    typedef enum logic {S_IDLE, S_WRITE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       time_q, time_d, time_inc;
    logic [7:0]        seq_q, seq_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              write_q, write_d;
    logic [3:0]        be_q, be_d;
    logic              wrapped_q, wrapped_d;
    logic              overrun_q, overrun_d;
    logic              clr_pend_q, clr_pend_d;
    logic              set_err_q, set_err_d;
    logic              tick, set_ok, eff_tick;

    // A BCD byte is legal when its low digit is a decimal digit and the
    // whole byte does not exceed the field maximum (which bounds the high digit).
    function automatic logic fld_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // One-second BCD increment with ss -> mm -> hh carries; hours wrap at 23.
    always_comb begin
        time_inc = time_q;
        if (time_q[3:0] != 4'd9) begin
            time_inc[3:0] = time_q[3:0] + 4'd1;
        end else begin
            time_inc[3:0] = 4'd0;
            if (time_q[7:4] != 4'd5) begin
                time_inc[7:4] = time_q[7:4] + 4'd1;
            end else begin
                time_inc[7:4] = 4'd0;
                if (time_q[11:8] != 4'd9) begin
                    time_inc[11:8] = time_q[11:8] + 4'd1;
                end else begin
                    time_inc[11:8] = 4'd0;
                    if (time_q[15:12] != 4'd5) begin
                        time_inc[15:12] = time_q[15:12] + 4'd1;
                    end else begin
                        time_inc[15:12] = 4'd0;
                        if (time_q[23:16] == 8'h23) begin
                            time_inc[23:16] = 8'h00;
                        end else if (time_q[19:16] == 4'd9) begin
                            time_inc[19:16] = 4'd0;
                            time_inc[23:20] = time_q[23:20] + 4'd1;
                        end else begin
                            time_inc[19:16] = time_q[19:16] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Prescaler, time/set handling, and the write-master FSM next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        time_d     = time_q;
        seq_d      = seq_q;
        wr_ptr_d   = wr_ptr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        be_d       = be_q;
        wrapped_d  = wrapped_q;
        overrun_d  = overrun_q;
        clr_pend_d = clr_pend_q;

        tick      = enable && (cnt_q == CNT_MAX);
        set_ok    = set_valid && fld_ok(set_time[23:16], 8'h23) &&
                    fld_ok(set_time[15:8], 8'h59) && fld_ok(set_time[7:0], 8'h59);
        set_err_d = set_valid && !set_ok;
        // An accepted set swallows a coincident tick entirely.
        eff_tick  = tick && !set_ok;

        if (set_ok || tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (set_ok) begin
            time_d = set_time;
        end else if (eff_tick) begin
            time_d = time_inc;
        end

        case (state_q)
            S_IDLE: begin
                // A clear (direct or deferred from a write) lands here; a
                // same-cycle tick then logs into the freshly cleared ring.
                if (clear || clr_pend_q) begin
                    wr_ptr_d   = PTR_BASE;
                    seq_d      = '0;
                    wrapped_d  = 1'b0;
                    overrun_d  = 1'b0;
                    clr_pend_d = 1'b0;
                end
                if (eff_tick) begin
                    state_d = S_WRITE;
                    write_d = 1'b1;
                    be_d    = 4'hF;
                    addr_d  = wr_ptr_d;
                    data_d  = {seq_d, time_inc};
                end
            end
            S_WRITE: begin
                if (eff_tick) overrun_d = 1'b1;
                if (clear) clr_pend_d = 1'b1;
                if (!avm_waitrequest) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                    write_d = 1'b0;
                    be_d    = 4'h0;
                    if (wr_ptr_q == PTR_LAST) begin
                        wr_ptr_d  = PTR_BASE;
                        wrapped_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears the bus outputs asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            time_q     <= '0;
            seq_q      <= '0;
            wr_ptr_q   <= PTR_BASE;
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            be_q       <= 4'h0;
            wrapped_q  <= 1'b0;
            overrun_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            time_q     <= time_d;
            seq_q      <= seq_d;
            wr_ptr_q   <= wr_ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_q    <= write_d;
            be_q       <= be_d;
            wrapped_q  <= wrapped_d;
            overrun_q  <= overrun_d;
            clr_pend_q <= clr_pend_d;
            set_err_q  <= set_err_d;
        end
    end

    assign time_bcd       = time_q;
    assign set_err        = set_err_q;
    assign avm_address    = addr_q;
    assign avm_chipselect = write_q;
    assign avm_write      = write_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = data_q;
    assign wr_ptr         = wr_ptr_q;
    assign wrapped        = wrapped_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_reloj_soc_time_logger.sv
// Bench for reloj_soc_time_logger: directed sequences, a set_time vector
// table, and a randomized run against a seconds-based reference model.
module tb_reloj_soc_time_logger;
    localparam int TD = 4, AW = 4, BASE = 8, DEPTH = 4;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          enable = 1'b0, clear = 1'b0, set_valid = 1'b0, avm_waitrequest = 1'b0;
    logic [23:0]   set_time = '0, time_bcd;
    logic          set_err, avm_chipselect, avm_write, wrapped, overrun;
    logic [AW-1:0] avm_address, wr_ptr;
    logic [3:0]    avm_byteenable;
    logic [31:0]   avm_writedata;

    reloj_soc_time_logger #(.TICK_DIV(TD), .ADDR_W(AW), .BASE_WORD(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .set_valid(set_valid), .set_time(set_time), .time_bcd(time_bcd), .set_err(set_err),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .wr_ptr(wr_ptr), .wrapped(wrapped), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: time is kept as seconds since midnight.
    int   m_cnt, m_secs, m_ptr, m_seq, m_addr;
    bit   m_busy, m_wrapped, m_overrun, m_pend, m_err;
    logic [31:0] m_rec;

    function automatic logic [23:0] to_bcd(input int secs);
        int h, m, s;
        logic [23:0] r;
        h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
        r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        return r;
    endfunction

    function automatic int fld(input logic [7:0] v);
        if (v[7:4] > 9 || v[3:0] > 9) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic int decode(input logic [23:0] t);
        int h, m, s;
        h = fld(t[23:16]); m = fld(t[15:8]); s = fld(t[7:0]);
        if (h < 0 || m < 0 || s < 0 || h > 23 || m > 59 || s > 59) return -1;
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_secs = 0; m_ptr = BASE; m_seq = 0; m_addr = 0;
        m_busy = 0; m_wrapped = 0; m_overrun = 0; m_pend = 0; m_err = 0; m_rec = '0;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit sv,
                              input logic [23:0] st, input bit wr);
        int  ss;
        bit  ok, tick, etick;
        ss    = decode(st);
        ok    = sv && (ss >= 0);
        tick  = en && (m_cnt == TD - 1);
        m_err = sv && !ok;
        etick = tick && !ok;
        if (ok || tick) m_cnt = 0;
        else if (en) m_cnt = m_cnt + 1;
        if (ok) m_secs = ss;
        else if (etick) m_secs = (m_secs + 1) % 86400;
        if (!m_busy) begin
            if (clr || m_pend) begin
                m_ptr = BASE; m_seq = 0; m_wrapped = 0; m_overrun = 0; m_pend = 0;
            end
            if (etick) begin
                m_busy = 1; m_addr = m_ptr;
                m_rec = {8'(m_seq), to_bcd(m_secs)};
            end
        end else begin
            if (etick) m_overrun = 1;
            if (clr) m_pend = 1;
            if (!wr) begin
                m_seq = (m_seq + 1) % 256;
                if (m_ptr == BASE + DEPTH - 1) begin m_ptr = BASE; m_wrapped = 1; end
                else m_ptr = m_ptr + 1;
                m_busy = 0;
            end
        end
    endtask

    task automatic compare_model();
        chk("m_time", time_bcd, to_bcd(m_secs));
        chk("m_write", avm_write, m_busy);
        chk("m_cs", avm_chipselect, m_busy);
        chk("m_be", avm_byteenable, m_busy ? 4'hF : 4'h0);
        chk("m_wr_ptr", wr_ptr, m_ptr);
        chk("m_wrapped", wrapped, m_wrapped);
        chk("m_overrun", overrun, m_overrun);
        chk("m_set_err", set_err, m_err);
        if (m_busy) begin
            chk("m_addr", avm_address, m_addr);
            chk("m_data", avm_writedata, m_rec);
        end
    endtask

    // Drive one cycle of inputs (from posedge+1), advance the model, and
    // compare after the next edge.
    task automatic cycle(input bit en, input bit clr, input bit sv,
                         input logic [23:0] st, input bit wr);
        enable = en; clear = clr; set_valid = sv; set_time = st; avm_waitrequest = wr;
        model_step(en, clr, sv, st, wr);
        @(posedge clk); #1;
        compare_model();
    endtask

    task automatic wait_write(input bit wr);
        for (int k = 0; k < 10 && !avm_write; k++) cycle(1, 0, 0, 24'h0, wr);
        chk("wait_write", avm_write, 1'b1);
    endtask

    typedef struct {
        logic [23:0] st;
        logic        err;
        logic [23:0] t_exp;
    } set_vec_t;

    set_vec_t vecs[10];
    logic [23:0]   recs[3];
    int            nrec;
    logic          prev_w;
    logic [AW-1:0] a0;
    logic [31:0]   d0;

    initial begin
        vecs[0] = '{24'h111111, 1'b0, 24'h111111};
        vecs[1] = '{24'h126000, 1'b1, 24'h111111};
        vecs[2] = '{24'h2A0000, 1'b1, 24'h111111};
        vecs[3] = '{24'h120000, 1'b0, 24'h120000};
        vecs[4] = '{24'h240000, 1'b1, 24'h120000};
        vecs[5] = '{24'h00000A, 1'b1, 24'h120000};
        vecs[6] = '{24'h235959, 1'b0, 24'h235959};
        vecs[7] = '{24'h0A0000, 1'b1, 24'h235959};
        vecs[8] = '{24'h000060, 1'b1, 24'h235959};
        vecs[9] = '{24'h095909, 1'b0, 24'h095909};

        // Reset values
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_time", time_bcd, 24'h0);
        chk("rst_write", avm_write, 1'b0);
        chk("rst_cs", avm_chipselect, 1'b0);
        chk("rst_be", avm_byteenable, 4'h0);
        chk("rst_addr", avm_address, '0);
        chk("rst_data", avm_writedata, 32'h0);
        chk("rst_wr_ptr", wr_ptr, BASE);
        chk("rst_flags", {wrapped, overrun, set_err}, 3'b000);
        reset_n = 1'b1;

        // First records and ring wrap: ticks at cycles 3,7,11,15,19
        for (int i = 1; i <= 21; i++) begin
            cycle(1, 0, 0, 24'h0, 0);
            if (i == 4) begin
                chk("first_write", avm_write, 1'b1);
                chk("first_addr", avm_address, BASE);
                chk("first_data", avm_writedata, 32'h00000001);
            end
            if (i == 5) begin
                chk("first_commit_w", avm_write, 1'b0);
                chk("first_commit_p", wr_ptr, BASE + 1);
            end
            if (i == 8) begin
                chk("second_addr", avm_address, BASE + 1);
                chk("second_data", avm_writedata, 32'h01000002);
            end
            if (i == 12) chk("third_addr", avm_address, BASE + 2);
            if (i == 16) begin
                chk("fourth_addr", avm_address, BASE + 3);
                chk("wrapped_pre", wrapped, 1'b0);
            end
            if (i == 17) chk("wrapped_post", wrapped, 1'b1);
            if (i == 20) begin
                chk("fifth_addr", avm_address, BASE);
                chk("fifth_data", avm_writedata, 32'h04000005);
            end
            if (i == 21) chk("end_wr_ptr", wr_ptr, BASE + 1);
        end

        // Midnight rollover: three consecutive records
        cycle(1, 0, 1, 24'h235958, 0);
        nrec = 0; prev_w = avm_write;
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0, 24'h0, 0);
            if (avm_write && !prev_w && nrec < 3) begin
                recs[nrec] = avm_writedata[23:0];
                nrec++;
            end
            prev_w = avm_write;
        end
        chk("roll_count", nrec, 3);
        chk("roll_rec0", recs[0], 24'h235959);
        chk("roll_rec1", recs[1], 24'h000000);
        chk("roll_rec2", recs[2], 24'h000001);

        // set_time validity vectors with the prescaler frozen
        foreach (vecs[i]) begin
            cycle(0, 0, 1, vecs[i].st, 0);
            chk("set_err_pulse", set_err, vecs[i].err);
            chk("set_time_res", time_bcd, vecs[i].t_exp);
            cycle(0, 0, 0, 24'h0, 0);
            chk("set_err_clr", set_err, 1'b0);
            chk("set_time_hold", time_bcd, vecs[i].t_exp);
        end

        // Stalled write: stable bus, second tick dropped, seq +1 only
        cycle(1, 1, 0, 24'h0, 1);
        cycle(1, 0, 1, 24'h000100, 1);
        wait_write(1);
        a0 = avm_address; d0 = avm_writedata;
        chk("stall_addr0", a0, BASE);
        chk("stall_data0", d0, 32'h00000101);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0, 24'h0, 1);
            chk("stall_addr", avm_address, a0);
            chk("stall_data", avm_writedata, d0);
            chk("stall_write", avm_write, 1'b1);
        end
        chk("stall_overrun", overrun, 1'b1);
        cycle(1, 0, 0, 24'h0, 0);
        chk("stall_commit", avm_write, 1'b0);
        chk("stall_ptr", wr_ptr, BASE + 1);
        wait_write(0);
        chk("stall_next_seq", avm_writedata[31:24], 8'd1);

        // Clear during a stalled write is deferred until after the commit
        cycle(1, 0, 0, 24'h0, 1);
        wait_write(1);
        a0 = avm_address;
        cycle(0, 1, 0, 24'h0, 1);
        chk("clr_hold_addr", avm_address, a0);
        cycle(0, 0, 0, 24'h0, 1);
        chk("clr_hold_w", avm_write, 1'b1);
        cycle(0, 0, 0, 24'h0, 0);
        chk("clr_commit_w", avm_write, 1'b0);
        chk("clr_commit_ptr", wr_ptr, (a0 == BASE + DEPTH - 1) ? BASE : a0 + 1);
        chk("clr_commit_ovr", overrun, 1'b1);
        cycle(0, 0, 0, 24'h0, 0);
        chk("clr_ptr", wr_ptr, BASE);
        chk("clr_ovr", overrun, 1'b0);
        chk("clr_wrap", wrapped, 1'b0);
        wait_write(0);
        chk("clr_seq", avm_writedata[31:24], 8'd0);
        chk("clr_addr", avm_address, BASE);

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            bit en, clr, sv, wr;
            logic [23:0] st;
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 63) == 0);
            sv  = ($urandom_range(0, 31) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            st  = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 86399)) : 24'($urandom);
            cycle(en, clr, sv, st, wr);
        end

        // Reset asserted mid-write drops the bus immediately
        cycle(1, 0, 0, 24'h0, 1);
        wait_write(1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_write", avm_write, 1'b0);
        chk("async_rst_ptr", wr_ptr, BASE);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/reloj_soc_time_logger.md
# reloj_soc_time_logger

Timekeeping and logging stage that drives the SoC's on-chip RAM as an Avalon-MM write master. It keeps a BCD hh:mm:ss clock from a clock-cycle prescaler and, once per second, writes a 32-bit timestamp record into a circular buffer of RAM words. The CPU reads the log through its own RAM slave port. This block never reads the RAM.

## Interface
Parameters:
- TICK_DIV, 50000000, clock cycles per second (≥2)
- ADDR_W, 11, RAM word-address width
- BASE_WORD, 0, first word of ring buffer
- DEPTH_WORDS, 2048, ring length in words (BASE_WORD+DEPTH_WORDS ≤ 2^ADDR_W)

Ports:
- clk  in  1  single clock; every register is in this domain
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  prescaler runs while high; freezes (holds count) while low
- clear  in  1  one-cycle pulse: reset ring pointer, seq, wrapped, overrun
- set_valid  in  1  one-cycle pulse: load set_time
- set_time  in  24  {hh,mm,ss} BCD
- time_bcd  out  24  current {hh,mm,ss} BCD
- set_err  out  1  one-cycle pulse: set_time rejected
- avm_address  out  ADDR_W  RAM word address
- avm_chipselect  out  1  asserted with avm_write
- avm_write  out  1  write request
- avm_byteenable  out  4  always 4'hF while writing, else 4'h0
- avm_writedata  out  32  record
- avm_waitrequest  in  1  interconnect stall
- wr_ptr  out  ADDR_W  next word to be written (absolute address)
- wrapped  out  1  sticky: ring has wrapped at least once
- overrun  out  1  sticky: a record was dropped

## Operation
- Record format: [31:24] seq (8-bit, increments per committed write, wraps 255→0); [23:0] time_bcd after the update.
- Prescaler 0..TICK_DIV-1. Tick = enable & (count == TICK_DIV-1). Count returns to 0 on tick.
- Time update on tick, BCD per digit with carry:
  - ss 59→00 carries to mm.
  - mm 59→00 carries to hh.
  - hh 23→00.
- Set:
  - set_valid with all fields valid loads time_bcd and zeroes the prescaler.
  - Valid means every nibble ≤9, ss ≤ 0x59, mm ≤ 0x59, hh ≤ 0x23.
  - Invalid: time and prescaler unchanged; set_err pulses for 1 cycle.
  - Set wins over a same-cycle tick. That tick is consumed: no time increment, no record.
- FSM states:
  - IDLE: write outputs deasserted. On tick, load record and go to WRITE.
  - WRITE: avm_chipselect = avm_write = 1, byteenable F. Address and data are held stable while avm_waitrequest = 1.
  - On an edge with avm_waitrequest = 0 the write commits:
    - seq++.
    - wr_ptr++, or wr_ptr → BASE_WORD if it was BASE_WORD+DEPTH_WORDS-1; that wrap sets wrapped.
    - Return to IDLE.
- Tick while in WRITE, including the commit cycle: time still updates, the new record is dropped, overrun is set.
- Clear:
  - In IDLE it takes effect at the next edge: wr_ptr = BASE_WORD, seq = 0, wrapped = overrun = 0.
  - In WRITE it is latched, then applied on the cycle after the commit. The in-flight record completes at its original address.
- Clear does not affect time_bcd or the prescaler.

## Timing
- Reset values:
  - time_bcd 0x000000, prescaler 0, state IDLE.
  - All avm_* outputs 0.
  - wr_ptr = BASE_WORD, seq 0, wrapped 0, overrun 0, set_err 0.
- Tick at cycle N:
  - time_bcd shows the new value from N+1.
  - avm_write is high from N+1.
  - With waitrequest low at N+1, the commit happens at the N+1→N+2 edge: wr_ptr and seq update in N+2 and avm_write is low in N+2.
- Minimum write occupancy is 1 cycle. Each waitrequest cycle adds 1.
- set_valid at cycle N: time_bcd is updated at N+1, or set_err is high during N+1 only.
- reset_n low mid-write drops avm_write asynchronously. No partial-state recovery is required.
- avm_* outputs are registered. No combinational path from avm_waitrequest to any output.

## Test plan
- Reset, TICK_DIV=4, enable=1, waitrequest=0 → first write at cycle 4 after reset release: addr BASE_WORD, data 0x00000001; next write addr +1, data 0x01000002.
- set_time 0x235958, run 3 ticks → records carry time 0x235959, 0x000000, 0x000001; no tick is lost across the rollover.
- set_time 0x126000, then 0x2A0000 → set_err pulses once for each, time_bcd unchanged; set 0x120000 is accepted.
- DEPTH_WORDS=4, BASE_WORD=8, 5 ticks → addresses 8,9,10,11,8. wrapped rises on the commit to 11; wr_ptr = 9 at the end.
- waitrequest held high 6 cycles with TICK_DIV=4 → address and data stable throughout; the second tick is dropped with overrun=1; seq advances by 1 only.
- clear during a stalled write → the write commits at its original address, then wr_ptr = BASE_WORD, seq 0, and overrun/wrapped are cleared on the following cycle.
